// File: rtl/serial_pattern_generator_if.sv
// Configuration handshake and serial output bundle for serial_pattern_generator.
// master = configuring side, slave = generator.
interface serial_pattern_generator_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 4,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [CNT_W-1:0]   reps;
  logic [CNT_W-1:0]   gap;
  logic               abort;
  logic               a;
  logic               a_valid;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, pattern, len, reps, gap, abort,
    input  cfg_ready, a, a_valid, busy, done
  );

  modport slave (
    input  cfg_valid, pattern, len, reps, gap, abort,
    output cfg_ready, a, a_valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_generator.sv
// Serial bit-stream transmitter: sends a configured pattern MSB-first, repeated
// reps+1 times with gap idle bits between copies.
//
// state | meaning
// IDLE  | waiting for a configuration; cfg_ready high
// SEND  | a carries a pattern bit this cycle
// GAP   | idle zero bits between two copies
module serial_pattern_generator #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 4,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input logic                       clk,
  input logic                       rst,
  serial_pattern_generator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] pat_reg;
  logic [MAX_LEN-1:0] sh;
  logic [LEN_W-1:0]   len_last;
  logic [LEN_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   copy_cnt;
  logic [CNT_W-1:0]   gap_reg;
  logic [CNT_W-1:0]   gap_cnt;

  logic [LEN_W-1:0]   len_eff;
  logic [MAX_LEN-1:0] pat_aligned;

  // Left-align the pattern so bit [len-1] always leaves from the MSB.
  always_comb begin
    len_eff     = (bus.len > MAX_LEN_L) ? MAX_LEN_L : bus.len;
    pat_aligned = bus.pattern << (MAX_LEN_L - len_eff);
  end

  assign bus.cfg_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pat_reg     <= '0;
      sh          <= '0;
      len_last    <= '0;
      bit_cnt     <= '0;
      copy_cnt    <= '0;
      gap_reg     <= '0;
      gap_cnt     <= '0;
      bus.a       <= 1'b0;
      bus.a_valid <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            if (len_eff == '0) begin
              bus.done <= 1'b1;
            end else begin
              state       <= SEND;
              pat_reg     <= pat_aligned;
              sh          <= pat_aligned << 1;
              bus.a       <= pat_aligned[MAX_LEN-1];
              bus.a_valid <= 1'b1;
              bus.busy    <= 1'b1;
              len_last    <= len_eff - LEN_W'(1);
              bit_cnt     <= len_eff - LEN_W'(1);
              copy_cnt    <= bus.reps;
              gap_reg     <= bus.gap;
            end
          end
        end
        SEND: begin
          if (bus.abort) begin
            state       <= IDLE;
            bus.a       <= 1'b0;
            bus.a_valid <= 1'b0;
            bus.busy    <= 1'b0;
          end else if (bit_cnt != '0) begin
            bus.a   <= sh[MAX_LEN-1];
            sh      <= sh << 1;
            bit_cnt <= bit_cnt - LEN_W'(1);
          end else if (copy_cnt != '0) begin
            copy_cnt <= copy_cnt - CNT_W'(1);
            if (gap_reg != '0) begin
              state       <= GAP;
              bus.a       <= 1'b0;
              bus.a_valid <= 1'b0;
              gap_cnt     <= gap_reg - CNT_W'(1);
            end else begin
              bus.a   <= pat_reg[MAX_LEN-1];
              sh      <= pat_reg << 1;
              bit_cnt <= len_last;
            end
          end else begin
            state       <= IDLE;
            bus.a       <= 1'b0;
            bus.a_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
          end
        end
        GAP: begin
          if (bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end else begin
            state       <= SEND;
            bus.a       <= pat_reg[MAX_LEN-1];
            bus.a_valid <= 1'b1;
            sh          <= pat_reg << 1;
            bit_cnt     <= len_last;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Bench for serial_pattern_generator: per-cycle expectation queue built from
// the stream rules, checked on every falling edge, plus literal latency checks.
module tb_serial_pattern_generator;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_pattern_generator_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus();

  serial_pattern_generator #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // expected outputs of one cycle: {a, a_valid, busy, done, cfg_ready}
  typedef struct packed {
    logic a;
    logic av;
    logic busy;
    logic done;
    logic rdy;
  } exp_t;

  localparam logic [4:0] IDLE_BITS = 5'b00001;

  exp_t exp_q[$];
  exp_t gen_q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   acc_cnt  = 0;
  int   acc_cyc  = 0;
  int   done_cyc = -1;
  logic cur_rdy  = 1'b1;
  logic cur_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Whole expected stream for one job, ending with the done/idle cycle.
  task automatic gen_stream(input logic [MAX_LEN-1:0] pat, input int len, input int reps, input int gap);
    int l;
    l = (len > MAX_LEN) ? MAX_LEN : len;
    gen_q.delete();
    if (l > 0) begin
      for (int c = 0; c <= reps; c++) begin
        for (int i = 0; i < l; i++) gen_q.push_back(exp_t'({pat[l-1-i], 4'b1100}));
        if (c < reps)
          for (int g = 0; g < gap; g++) gen_q.push_back(exp_t'(5'b00100));
      end
    end
    gen_q.push_back(exp_t'(5'b00011));
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      if (bus.abort && cur_busy) begin
        exp_q.delete();
      end else if (bus.cfg_valid && cur_rdy) begin
        gen_stream(bus.pattern, int'(bus.len), int'(bus.reps), int'(bus.gap));
        foreach (gen_q[j]) exp_q.push_back(gen_q[j]);
        acc_cnt++;
        acc_cyc = cyc - 1;
      end
    end
  end

  always @(negedge rst) begin
    exp_q.delete();
    cur_rdy  = 1'b1;
    cur_busy = 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst || exp_q.size() == 0) e = exp_t'(IDLE_BITS);
    else e = exp_q.pop_front();
    cur_rdy  = e.rdy;
    cur_busy = e.busy;
    chk("a", 32'(bus.a), 32'(e.a));
    chk("a_valid", 32'(bus.a_valid), 32'(e.av));
    chk("busy", 32'(bus.busy), 32'(e.busy));
    chk("done", 32'(bus.done), 32'(e.done));
    chk("cfg_ready", 32'(bus.cfg_ready), 32'(e.rdy));
    if (bus.done === 1'b1) done_cyc = cyc;
  end

  task automatic set_cfg(input logic [MAX_LEN-1:0] p, input int l, input int r, input int g);
    bus.pattern = p;
    bus.len     = LEN_W'(l);
    bus.reps    = CNT_W'(r);
    bus.gap     = CNT_W'(g);
  endtask

  task automatic wait_accept(input int prev, input int budget);
    int n = 0;
    while (acc_cnt == prev && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (acc_cnt == prev) begin
      errors++;
      $display("FAIL accept_timeout: no accept within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout: job still running after %0d cycles", budget);
    end
  endtask

  task automatic run_job(input string name, input logic [MAX_LEN-1:0] p, input int l,
                         input int r, input int g, input int exp_lat);
    int prev;
    prev     = acc_cnt;
    done_cyc = -1;
    set_cfg(p, l, r, g);
    bus.cfg_valid = 1'b1;
    wait_accept(prev, 20);
    bus.cfg_valid = 1'b0;
    wait_idle(400);
    chk(name, 32'(done_cyc - acc_cyc), 32'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] va, vv;
    int prev, k, a1;

    bus.cfg_valid = 1'b0;
    bus.abort     = 1'b0;
    set_cfg('0, 0, 0, 0);

    // pin the model against hand-derived streams
    gen_stream(8'b0011_0011, 6, 1, 2);
    chk("pin_len", 32'(gen_q.size()), 32'd15);
    for (int i = 0; i < 14; i++) begin
      va[13-i] = gen_q[i].a;
      vv[13-i] = gen_q[i].av;
    end
    chk("pin_a", 32'(va), 32'(14'b11001100110011));
    chk("pin_av", 32'(vv), 32'(14'b11111100111111));
    chk("pin_done", 32'(gen_q[14].done), 32'd1);
    gen_stream(8'b0000_0010, 2, 15, 15);
    chk("pin_max", 32'(gen_q.size()), 32'd258);
    gen_stream(8'hFF, 0, 3, 2);
    chk("pin_len0", 32'(gen_q.size()), 32'd1);
    gen_stream(8'b1011_0010, 15, 0, 0);
    chk("pin_clamp", 32'(gen_q.size()), 32'd9);

    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    #1 rst = 1'b1;
    @(negedge clk); #1;

    run_job("single_done_lat", 8'b0000_0110, 4, 0, 0, 5);
    run_job("gap_done_lat", 8'b0011_0011, 6, 1, 2, 15);

    // back-to-back with cfg_valid held high
    prev     = acc_cnt;
    done_cyc = -1;
    set_cfg(8'b0000_1010, 4, 0, 0);
    bus.cfg_valid = 1'b1;
    wait_accept(prev, 20);
    a1 = acc_cyc;
    set_cfg(8'b0000_0101, 3, 0, 0);
    wait_accept(prev + 1, 20);
    bus.cfg_valid = 1'b0;
    chk("b2b_accept_spacing", 32'(acc_cyc - a1), 32'd5);
    wait_idle(100);
    chk("b2b_done_lat", 32'(done_cyc - acc_cyc), 32'd4);

    run_job("len0_done_lat", 8'hFF, 0, 3, 2, 1);
    run_job("clamp_done_lat", 8'b1011_0010, 15, 0, 0, 9);
    run_job("max_done_lat", 8'b0000_0010, 2, 15, 15, 258);

    // abort on the 3rd bit of a 2-copy job, re-accept the next cycle
    prev = acc_cnt;
    set_cfg(8'b0000_1011, 4, 1, 1);
    bus.cfg_valid = 1'b1;
    wait_accept(prev, 20);
    bus.cfg_valid = 1'b0;
    k = acc_cyc;
    @(negedge clk); #1;
    @(negedge clk); #1;
    bus.abort = 1'b1;
    set_cfg(8'b0000_0101, 3, 0, 0);
    bus.cfg_valid = 1'b1;
    @(negedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_a_valid", 32'(bus.a_valid), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    done_cyc = -1;
    wait_accept(prev + 1, 5);
    bus.cfg_valid = 1'b0;
    chk("abort_reaccept_cycle", 32'(acc_cyc - k), 32'd4);
    wait_idle(50);
    chk("after_abort_done_lat", 32'(done_cyc - acc_cyc), 32'd4);

    // asynchronous reset in the middle of a gap
    prev = acc_cnt;
    set_cfg(8'b0000_0011, 2, 1, 3);
    bus.cfg_valid = 1'b1;
    wait_accept(prev, 20);
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #2;
    chk("gap_busy", 32'(bus.busy), 32'd1);
    chk("gap_a_valid", 32'(bus.a_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("arst_a", 32'(bus.a), 32'd0);
    chk("arst_a_valid", 32'(bus.a_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    set_cfg(8'b0000_1101, 4, 0, 1);
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    prev = acc_cnt;
    done_cyc = -1;
    rst = 1'b1;
    wait_accept(prev, 5);
    bus.cfg_valid = 1'b0;
    wait_idle(50);
    chk("post_rst_done_lat", 32'(done_cyc - acc_cyc), 32'd5);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
